// File: rtl/inst_fetch_ctrl_if.sv
// Instruction-bus handshake between the fetch controller (master) and the
// instruction memory or bus slave.
interface inst_fetch_ctrl_if;
   logic        bus_req_o;
   logic [31:0] bus_addr_o;
   logic        bus_ack_i;
   logic [31:0] bus_data_i;

   modport master (
      output bus_req_o,
      output bus_addr_o,
      input  bus_ack_i,
      input  bus_data_i
   );

   modport slave (
      input  bus_req_o,
      input  bus_addr_o,
      output bus_ack_i,
      output bus_data_i
   );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch responder: one bus read per PC, holds the pipeline until
// the word is ready, and turns flushes and bus timeouts into NOP_INST.
//
// state | meaning
// IDLE  | sample pc_i; launch a read or deliver NOP for a misaligned PC
// REQ   | read outstanding, result goes to IF/ID
// DONE  | word presented on inst_o, waiting for the PC stage to advance
// DRAIN | read outstanding after a flush, result is discarded
module inst_fetch_ctrl #(
   parameter logic [31:0] NOP_INST       = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              pc_i,
   input  logic [5:0]               stall_i,
   input  logic                     flush_i,
   inst_fetch_ctrl_if.master        bus,
   output logic [31:0]              inst_o,
   output logic                     stallRequest_o,
   output logic                     busError_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

   state_t                 state, state_nxt;
   logic                   bus_req, bus_req_nxt;
   logic [31:0]            bus_addr, bus_addr_nxt;
   logic [31:0]            inst, inst_nxt;
   logic                   bus_err, bus_err_nxt;
   logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;

   logic                   launch;
   logic                   load_data;
   logic                   load_nop;
   logic                   end_read;
   logic                   timeout;
   logic                   wait_end;
   logic                   unused_stall;

   assign unused_stall = ^stall_i[5:1];
   assign wait_end     = (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         bus_req  <= 1'b0;
         bus_addr <= 32'h0;
         inst     <= NOP_INST;
         bus_err  <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nxt;
         bus_req  <= bus_req_nxt;
         bus_addr <= bus_addr_nxt;
         inst     <= inst_nxt;
         bus_err  <= bus_err_nxt;
         cnt      <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      launch    = 1'b0;
      load_data = 1'b0;
      load_nop  = 1'b0;
      end_read  = 1'b0;
      timeout   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (flush_i) begin
               load_nop = 1'b1;
            end else if (pc_i[1:0] == 2'b00) begin
               launch    = 1'b1;
               state_nxt = ST_REQ;
            end else begin
               load_nop  = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_REQ: begin
            if (bus.bus_ack_i) begin
               end_read = 1'b1;
               if (flush_i) begin
                  load_nop  = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  load_data = 1'b1;
                  state_nxt = ST_DONE;
               end
            end else if (wait_end) begin
               // A flush coinciding with the timeout still restarts from IDLE.
               end_read  = 1'b1;
               timeout   = 1'b1;
               load_nop  = 1'b1;
               state_nxt = flush_i ? ST_IDLE : ST_DONE;
            end else if (flush_i) begin
               state_nxt = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (flush_i) begin
               load_nop  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (!stall_i[0]) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (bus.bus_ack_i || wait_end) begin
               end_read  = 1'b1;
               timeout   = !bus.bus_ack_i;
               load_nop  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      bus_req_nxt  = bus_req;
      bus_addr_nxt = bus_addr;
      inst_nxt     = inst;
      cnt_nxt      = cnt;
      bus_err_nxt  = timeout;
      if (launch) begin
         bus_req_nxt  = 1'b1;
         bus_addr_nxt = pc_i;
         cnt_nxt      = '0;
      end else if (end_read) begin
         bus_req_nxt  = 1'b0;
      end
      if (load_data) begin
         inst_nxt = bus.bus_data_i;
      end else if (load_nop) begin
         inst_nxt = NOP_INST;
      end
      if ((state == ST_REQ || state == ST_DRAIN) && !wait_end) begin
         cnt_nxt = cnt + CNT_WIDTH'(1);
      end
   end

   assign bus.bus_req_o  = bus_req;
   assign bus.bus_addr_o = bus_addr;
   assign inst_o         = inst;
   assign busError_o     = bus_err;
   assign stallRequest_o = (state != ST_DONE);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed and random stimulus for inst_fetch_ctrl, checked every cycle
// against a transaction-level model of the fetch unit.
module tb_inst_fetch_ctrl;
   localparam int          T_OUT = 8;
   localparam logic [31:0] NOP   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_i;
   logic [5:0]  stall_i;
   logic        flush_i;
   logic [31:0] inst_o;
   logic        stallRequest_o;
   logic        busError_o;

   int checks = 0;
   int errors = 0;

   inst_fetch_ctrl_if bus_if ();

   inst_fetch_ctrl #(
      .NOP_INST       (NOP),
      .TIMEOUT_CYCLES (T_OUT),
      .CNT_WIDTH      (8)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_i           (pc_i),
      .stall_i        (stall_i),
      .flush_i        (flush_i),
      .bus            (bus_if),
      .inst_o         (inst_o),
      .stallRequest_o (stallRequest_o),
      .busError_o     (busError_o)
   );

   always #5 clk = ~clk;

   // Model: a read is either outstanding (m_busy) or not; a busy read may be
   // marked for discard; m_have says a word is being presented to IF/ID.
   bit          m_busy, m_discard, m_have, m_err;
   int          m_waited;
   logic [31:0] m_addr, m_inst;

   task automatic model_reset();
      m_busy = 0; m_discard = 0; m_have = 0; m_err = 0; m_waited = 0;
      m_addr = 32'h0; m_inst = NOP;
   endtask

   task automatic model_step(input logic [31:0] pc, input logic s0, input logic fl,
                             input logic ak, input logic [31:0] dt);
      m_err = 0;
      if (m_busy) begin
         if (ak) begin
            m_busy = 0;
            m_have = !(m_discard || fl);
            m_inst = m_have ? dt : NOP;
         end else if (m_waited + 1 >= T_OUT) begin
            m_busy = 0;
            m_err  = 1;
            m_have = !(m_discard || fl);
            m_inst = NOP;
         end else begin
            m_waited++;
            if (fl) m_discard = 1;
         end
      end else if (m_have) begin
         if (fl) begin
            m_inst = NOP;
            m_have = 0;
         end else if (!s0) begin
            m_have = 0;
         end
      end else begin
         if (fl) begin
            m_inst = NOP;
         end else if (pc % 4 == 0) begin
            m_busy = 1; m_discard = 0; m_waited = 0; m_addr = pc;
         end else begin
            m_inst = NOP;
            m_have = 1;
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%08h expected=%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("bus_req",  {31'b0, bus_if.bus_req_o}, {31'b0, m_busy});
      check("bus_addr", bus_if.bus_addr_o, m_addr);
      check("inst",     inst_o, m_inst);
      check("stall_req", {31'b0, stallRequest_o}, {31'b0, !m_have});
      check("bus_err",  {31'b0, busError_o}, {31'b0, m_err});
   endtask

   task automatic step(input logic [31:0] pc, input logic [5:0] st, input logic fl,
                       input logic ak, input logic [31:0] dt);
      pc_i = pc; stall_i = st; flush_i = fl;
      bus_if.bus_ack_i = ak; bus_if.bus_data_i = dt;
      @(posedge clk); #1;
      model_step(pc, st[0], fl, ak, dt);
      compare_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      compare_all();
   endtask

   initial begin
      logic [31:0] pc_r;
      rst = 1'b0; pc_i = 32'h0; stall_i = 6'h0; flush_i = 1'b0;
      bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = 32'h0;
      model_reset();
      @(negedge clk);
      do_reset();
      check("rst_stall", {31'b0, stallRequest_o}, 32'd1);

      // zero-wait fetch
      step(32'h8000_0000, 6'h0, 0, 0, 32'h0);
      check("zw_req", {31'b0, bus_if.bus_req_o}, 32'd1);
      step(32'h8000_0000, 6'h0, 0, 1, 32'h2408_0001);
      check("zw_inst", inst_o, 32'h2408_0001);
      check("zw_done_stall", {31'b0, stallRequest_o}, 32'd0);

      // held in DONE by stall_i[0]
      for (int i = 0; i < 4; i++) step(32'h8000_0000, 6'h01, 0, i == 2, 32'h1111_1111);
      check("stall_inst", inst_o, 32'h2408_0001);
      step(32'h8000_0004, 6'h00, 0, 0, 32'h0);
      step(32'h8000_0004, 6'h00, 0, 0, 32'h0);
      check("next_addr", bus_if.bus_addr_o, 32'h8000_0004);

      // ack after 5 REQ cycles
      for (int i = 0; i < 4; i++) step(32'h8000_0004, 6'h0, 0, 0, 32'h0);
      step(32'h8000_0004, 6'h0, 0, 1, 32'h3c01_1234);
      check("slow_inst", inst_o, 32'h3c01_1234);
      step(32'h8000_0008, 6'h0, 0, 0, 32'h0);

      // flush during REQ, late ack with poisoned data
      step(32'h8000_0008, 6'h0, 0, 0, 32'h0);
      step(32'h8000_0008, 6'h0, 1, 0, 32'h0);
      step(32'h8000_0100, 6'h0, 0, 0, 32'h0);
      step(32'h8000_0100, 6'h0, 0, 1, 32'hDEAD_BEEF);
      check("drain_inst", inst_o, NOP);
      step(32'h8000_0100, 6'h0, 0, 0, 32'h0);
      check("post_flush_addr", bus_if.bus_addr_o, 32'h8000_0100);
      step(32'h8000_0100, 6'h0, 0, 1, 32'h0000_0abc);
      step(32'h8000_0200, 6'h0, 0, 0, 32'h0);

      // timeout
      step(32'h8000_0200, 6'h0, 0, 0, 32'h0);
      for (int i = 0; i < T_OUT; i++) step(32'h8000_0200, 6'h0, 0, 0, 32'h0);
      check("to_err", {31'b0, busError_o}, 32'd1);
      check("to_inst", inst_o, NOP);
      step(32'h8000_0204, 6'h0, 0, 0, 32'h0);
      check("to_err_pulse", {31'b0, busError_o}, 32'd0);

      // misaligned PC
      step(32'h8000_0002, 6'h0, 0, 0, 32'h0);
      check("mis_req", {31'b0, bus_if.bus_req_o}, 32'd0);
      step(32'h8000_0008, 6'h0, 0, 0, 32'h0);

      // reset while a read is outstanding
      step(32'h8000_0008, 6'h0, 0, 0, 32'h0);
      step(32'h8000_0008, 6'h0, 0, 0, 32'h0);
      do_reset();
      check("rst_mid_req", {31'b0, bus_if.bus_req_o}, 32'd0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         pc_r = $urandom;
         if ($urandom_range(7) != 0) pc_r[1:0] = 2'b00;
         step(pc_r, 6'($urandom_range(63)) & ($urandom_range(2) == 0 ? 6'h3f : 6'h3e),
              $urandom_range(9) == 0, $urandom_range(3) == 0, $urandom);
         if ($urandom_range(499) == 0) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
